ddr_prog_dly_enc: RTL
=====================

DDR_PROG_DLY_ENC -- requirements
Module: ddr_prog_dly_enc

Interface
REQ-001 Parameter TWIDTH, default 32, thermometer width of the programmable delay line.
REQ-002 Parameter STABLE_CYC, default 4, consecutive identical samples required before encoding.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles allowed in SETTLE before an unstable error is flagged.
REQ-004 i_clk  input  1  block clock; the only clock.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_req  input  1  start one encode; honoured only when o_busy=0.
REQ-007 i_code_therm  input  TWIDTH  delay-line thermometer readback; may toggle asynchronously to the request.
REQ-008 i_code_fine  input  2  delay-line 2-bit fine readback.
REQ-009 o_busy  output  1  encode in progress.
REQ-010 o_valid  output  1  single-cycle pulse; result fields are valid.
REQ-011 o_code_bin  output  8  recovered binary delay code, held until the next o_valid.
REQ-012 o_err_bubble  output  1  thermometer is non-contiguous, or fine≠2'b11 while therm≠0; held with o_code_bin.
REQ-013 o_err_unstable  output  1  inputs never held stable for STABLE_CYC samples before timeout; held with o_code_bin.

Function
REQ-014 FSM states: IDLE, SETTLE, ENCODE, DONE; encoded with a package enum.
REQ-015 IDLE: o_busy=0; i_req=1 -> SETTLE, capture {therm,fine} into the sample register, clear stable counter and timeout counter.
REQ-016 SETTLE: each cycle, compare live inputs with the sample register; on match, stable_cnt+1; on mismatch, reload the sample register and set stable_cnt=0.
REQ-017 SETTLE -> ENCODE when stable_cnt reaches STABLE_CYC-1; SETTLE -> DONE with o_err_unstable=1 and o_code_bin=0 when timeout_cnt reaches TIMEOUT_CYC.
REQ-018 If stable and timeout conditions hit in the same cycle, stable takes priority (ENCODE, no error).
REQ-019 ENCODE (one cycle, registered result) when therm==0: code = {6'b0, fine}, giving values 0..3.
REQ-020 ENCODE when therm≠0: code = 3 + popcount(therm), giving values 4..35 for TWIDTH=32; the popcount is TWIDTH-sized and zero-extended to 8 bits.
REQ-021 Bubble check: therm is legal when therm & (therm+1) == 0, i.e. contiguous ones from bit 0.
- Illegal therm, or therm≠0 with fine≠2'b11 -> o_err_bubble=1.
- o_code_bin is still the REQ-020 popcount result.
REQ-022 DONE (one cycle): o_valid=1 -> IDLE. Latency from i_req to o_valid is STABLE_CYC+2 cycles for static inputs.
REQ-023 i_req during o_busy=1 is ignored; no queueing.
REQ-024 o_busy=1 in SETTLE, ENCODE, DONE.
REQ-025 Round-trip property: for any decoder input c in 0..35, encoding the decoder's outputs yields c with no error; decoder inputs >35 encode to 35.

Reset
REQ-026 i_rst_n=0 at a rising edge forces state IDLE, all counters and the sample register to 0, and all outputs to 0 (o_busy, o_valid, o_code_bin, o_err_bubble, o_err_unstable).
REQ-027 Reset mid-operation aborts the encode with no o_valid; the first i_req after i_rst_n=1 is honoured normally.

Structure
REQ-028 The FSM state enum and the constants DLY_FINE_MAX=3 and DLY_CODE_MAX=35 belong in ddr_global_pkg.
REQ-029 One sub-module, ddr_prog_dly_popcnt (combinational, TWIDTH-parameterised popcount plus contiguity flag), is instantiated once.
REQ-030 There are no latches, and all state is clocked by i_clk only.

Verification
REQ-031 Static therm=32'h0000_0000, fine=2'b10, i_req pulse -> o_valid at cycle 6, o_code_bin=2, no errors.
REQ-032 Sweep decoder codes 0..40 through a reference decoder into the block -> o_code_bin = min(c,35) and errors=0 every time.
REQ-033 therm=32'h0000_00F7 (bubble), fine=2'b11 -> o_code_bin=10, o_err_bubble=1.
REQ-034 therm=32'h0000_0003, fine=2'b01 -> o_code_bin=5, o_err_bubble=1.
REQ-035 Toggle therm bit 0 every 2 cycles during SETTLE -> o_valid after 256 cycles, o_err_unstable=1, o_code_bin=0.
REQ-036 Assert i_rst_n=0 in SETTLE, then a second i_req mid-busy -> no o_valid until a fresh i_req after reset, and the mid-busy request is ignored.

Source files
------------

// File: rtl/ddr_global_pkg.sv
// Shared DDR PHY definitions: programmable-delay encoder FSM states and delay-code limits.
package ddr_global_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ENCODE = 2'd2,
        ST_DONE   = 2'd3
    } dly_enc_state_t;

    localparam int unsigned DLY_FINE_MAX = 3;
    localparam int unsigned DLY_CODE_MAX = 35;

endpackage

// File: rtl/ddr_prog_dly_popcnt.sv
// Combinational population count of a delay-line thermometer, plus a flag that is set when
// the ones run contiguously from bit 0.
module ddr_prog_dly_popcnt #(
    parameter int unsigned TWIDTH = 32,
    parameter int unsigned CW     = $clog2(TWIDTH + 1)
) (
    input  logic [TWIDTH-1:0] therm,
    output logic [CW-1:0]     count,
    output logic              contig
);

    logic [TWIDTH-1:0] therm_inc;

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < TWIDTH; i++) begin
            count = count + CW'(therm[i]);
        end
    end

    // Adding one to a legal thermometer carries through every set bit, so no bit survives the AND.
    always_comb begin
        therm_inc = therm + TWIDTH'(1);
        contig    = ((therm & therm_inc) == '0);
    end

endmodule

// File: rtl/ddr_prog_dly_enc.sv
// Programmable delay-line readback encoder: waits for the thermometer/fine readback to settle,
// then converts it to a binary delay code with bubble and stability error flags.
module ddr_prog_dly_enc
    import ddr_global_pkg::*;
#(
    parameter int unsigned TWIDTH      = 32,
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [TWIDTH-1:0] i_code_therm,
    input  logic [1:0]        i_code_fine,
    output logic              o_busy,
    output logic              o_valid,
    output logic [7:0]        o_code_bin,
    output logic              o_err_bubble,
    output logic              o_err_unstable
);

    localparam int unsigned SW = $clog2(STABLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CW = $clog2(TWIDTH + 1);

    dly_enc_state_t    state;
    logic [TWIDTH-1:0] samp_therm;
    logic [1:0]        samp_fine;
    logic [SW-1:0]     stable_cnt;
    logic [TW-1:0]     timeout_cnt;

    logic [CW-1:0]     pop;
    logic              contig;
    logic              match;
    logic              hit_stable;
    logic              hit_timeout;
    logic [7:0]        enc_code;
    logic              enc_bubble;

    ddr_prog_dly_popcnt #(
        .TWIDTH (TWIDTH),
        .CW     (CW)
    ) u_popcnt (
        .therm  (samp_therm),
        .count  (pop),
        .contig (contig)
    );

    always_comb begin
        match       = (i_code_therm == samp_therm) && (i_code_fine == samp_fine);
        hit_stable  = match && (stable_cnt == SW'(STABLE_CYC - 1));
        hit_timeout = (timeout_cnt == TW'(TIMEOUT_CYC - 1));
    end

    // An all-zero thermometer means only the fine taps are in use; otherwise the fine
    // section must be saturated and the coarse count sits on top of it.
    always_comb begin
        enc_code   = '0;
        enc_bubble = 1'b0;
        if (samp_therm == '0) begin
            enc_code = {6'b0, samp_fine};
        end else begin
            enc_code   = 8'(pop) + 8'(DLY_FINE_MAX);
            enc_bubble = !contig || (samp_fine != 2'(DLY_FINE_MAX));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            samp_therm     <= '0;
            samp_fine      <= '0;
            stable_cnt     <= '0;
            timeout_cnt    <= '0;
            o_busy         <= 1'b0;
            o_valid        <= 1'b0;
            o_code_bin     <= '0;
            o_err_bubble   <= 1'b0;
            o_err_unstable <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        state       <= ST_SETTLE;
                        o_busy      <= 1'b1;
                        samp_therm  <= i_code_therm;
                        samp_fine   <= i_code_fine;
                        stable_cnt  <= '0;
                        timeout_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    timeout_cnt <= timeout_cnt + TW'(1);
                    if (match) begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end else begin
                        samp_therm <= i_code_therm;
                        samp_fine  <= i_code_fine;
                        stable_cnt <= '0;
                    end
                    // Stability wins over a coincident timeout.
                    if (hit_stable) begin
                        state <= ST_ENCODE;
                    end else if (hit_timeout) begin
                        state          <= ST_DONE;
                        o_valid        <= 1'b1;
                        o_code_bin     <= '0;
                        o_err_bubble   <= 1'b0;
                        o_err_unstable <= 1'b1;
                    end
                end
                ST_ENCODE: begin
                    state          <= ST_DONE;
                    o_valid        <= 1'b1;
                    o_code_bin     <= enc_code;
                    o_err_bubble   <= enc_bubble;
                    o_err_unstable <= 1'b0;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
